// File: rtl/result_checker_if.sv
// Result-bus checker interface: table load, run control, result stream and status.
// Optional RESULT_CHECKER_CAPTURE_EN adds first-mismatch capture outputs.
interface result_checker_if #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic             exp_we;
  logic [AW-1:0]    exp_addr;
  logic [WIDTH-1:0] exp_data;
  logic [AW:0]      exp_len;
  logic             start;
  logic             valid;
  logic [WIDTH-1:0] result;
  logic             busy;
  logic             done;
  logic             pass;
  logic             fail;
  logic             timeout;
  logic [AW:0]      err_count;
  logic [AW-1:0]    first_err_idx;
  logic [31:0]      cycle_count;
`ifdef RESULT_CHECKER_CAPTURE_EN
  logic [WIDTH-1:0] mism_got;
  logic [WIDTH-1:0] mism_exp;
`endif

  modport master (
    output exp_we, exp_addr, exp_data, exp_len,
    output start, valid, result,
    input  busy, done, pass, fail, timeout,
    input  err_count, first_err_idx, cycle_count
`ifdef RESULT_CHECKER_CAPTURE_EN
    , input mism_got, mism_exp
`endif
  );

  modport slave (
    input  exp_we, exp_addr, exp_data, exp_len,
    input  start, valid, result,
    output busy, done, pass, fail, timeout,
    output err_count, first_err_idx, cycle_count
`ifdef RESULT_CHECKER_CAPTURE_EN
    , output mism_got, mism_exp
`endif
  );
endinterface

// File: rtl/result_checker.sv
// Self-checking monitor: compares retired results against a loaded table.
// RESULT_CHECKER_CAPTURE_EN adds capture of the first mismatching pair.
module result_checker #(
  parameter int WIDTH   = 32,
  parameter int DEPTH   = 16,
  parameter int TIMEOUT = 400
) (
  input logic           clk,
  input logic           rst,
  result_checker_if.slave bus
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] LEN_MAX = (AW+1)'(DEPTH);
  localparam logic [31:0] TO_LAST = 32'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    idx;
  logic [AW:0]      len;

  logic [WIDTH-1:0] exp_cur;
  logic             samp;
  logic             mism;
  logic             last;
  logic             to_hit;
  logic [AW:0]      err_inc;
  logic [AW:0]      len_in;

  // Combinational compare against the table entry at the current index.
  always_comb begin
    exp_cur = mem[idx];
    samp    = bus.valid && (len != '0);
    mism    = samp && (bus.result != exp_cur);
    last    = (len == '0) ||
              (samp && ({1'b0, idx} == len - 1'b1));
    to_hit  = (bus.cycle_count == TO_LAST);
    err_inc = (bus.err_count == LEN_MAX) ?
              bus.err_count : bus.err_count + 1'b1;
    len_in  = (bus.exp_len > LEN_MAX) ?
              LEN_MAX : bus.exp_len;
  end

  // Table load; locked while a run is in progress so it never races the compare.
  always_ff @(posedge clk) begin
    if (bus.exp_we && state != RUN)
      mem[bus.exp_addr] <= bus.exp_data;
  end

  // Run control FSM with registered status outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state             <= IDLE;
      idx               <= '0;
      len               <= '0;
      bus.busy          <= 1'b0;
      bus.done          <= 1'b0;
      bus.pass          <= 1'b0;
      bus.fail          <= 1'b0;
      bus.timeout       <= 1'b0;
      bus.err_count     <= '0;
      bus.first_err_idx <= '0;
      bus.cycle_count   <= '0;
`ifdef RESULT_CHECKER_CAPTURE_EN
      bus.mism_got      <= '0;
      bus.mism_exp      <= '0;
`endif
    end else begin
      unique case (state)
        IDLE, DONE: begin
          if (bus.start) begin
            state             <= RUN;
            idx               <= '0;
            len               <= len_in;
            bus.busy          <= 1'b1;
            bus.done          <= 1'b0;
            bus.pass          <= 1'b0;
            bus.fail          <= 1'b0;
            bus.timeout       <= 1'b0;
            bus.err_count     <= '0;
            bus.first_err_idx <= '0;
            bus.cycle_count   <= '0;
`ifdef RESULT_CHECKER_CAPTURE_EN
            bus.mism_got      <= '0;
            bus.mism_exp      <= '0;
`endif
          end
        end
        RUN: begin
          bus.cycle_count <= bus.cycle_count + 32'd1;
          if (samp)
            idx <= idx + 1'b1;
          if (mism) begin
            bus.err_count <= err_inc;
            if (bus.err_count == '0) begin
              bus.first_err_idx <= idx;
`ifdef RESULT_CHECKER_CAPTURE_EN
              bus.mism_got      <= bus.result;
              bus.mism_exp      <= exp_cur;
`endif
            end
          end
          // Final sample outranks a coincident timeout.
          if (last) begin
            state    <= DONE;
            bus.busy <= 1'b0;
            bus.done <= 1'b1;
            bus.pass <= (bus.err_count == '0) && !mism;
            bus.fail <= (bus.err_count != '0) || mism;
          end else if (to_hit) begin
            state       <= DONE;
            bus.busy    <= 1'b0;
            bus.done    <= 1'b1;
            bus.timeout <= 1'b1;
            bus.fail    <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_result_checker.sv
// Directed bench for result_checker with a transaction-level reference model.
// Build with RESULT_CHECKER_CAPTURE_EN to also check mismatch capture.
module tb_result_checker;
  localparam int W  = 32;
  localparam int D  = 16;
  localparam int TO = 400;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;
  bit   chk_en = 0;

  always #5 clk = ~clk;

  result_checker_if #(.WIDTH(W), .DEPTH(D)) bus ();

  result_checker #(.WIDTH(W), .DEPTH(D), .TIMEOUT(TO)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // Reference model: counts of samples sent/erroneous per run.
  bit          m_run, m_done, m_to;
  int          m_len, m_sent, m_errs, m_first, m_cyc;
  logic [31:0] m_tab [D];
  logic [31:0] m_got, m_exp;

  task automatic check(input string nm,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      if (bad < 40)
        $display("FAIL %s: got=%0d want=%0d t=%0t",
                 nm, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_run = 0; m_done = 0; m_to = 0;
    m_len = 0; m_sent = 0; m_errs = 0;
    m_first = 0; m_cyc = 0;
    m_got = '0; m_exp = '0;
  endtask

  task automatic model_step();
    if (!m_run) begin
      if (bus.exp_we) m_tab[bus.exp_addr] = bus.exp_data;
      if (bus.start) begin
        model_reset();
        m_run = 1;
        m_len = (bus.exp_len > D) ? D : int'(bus.exp_len);
      end
    end else begin
      m_cyc++;
      if (bus.valid && m_sent < m_len) begin
        if (bus.result != m_tab[m_sent]) begin
          if (m_errs == 0) begin
            m_first = m_sent;
            m_got = bus.result;
            m_exp = m_tab[m_sent];
          end
          if (m_errs < D) m_errs++;
        end
        m_sent++;
      end
      if (m_sent == m_len) begin
        m_run = 0; m_done = 1;
      end else if (m_cyc == TO) begin
        m_run = 0; m_done = 1; m_to = 1;
      end
    end
  endtask

  // Continuous comparison of every status output against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("busy", 32'(bus.busy), 32'(m_run));
      check("done", 32'(bus.done), 32'(m_done));
      check("pass", 32'(bus.pass),
            32'(m_done && m_errs == 0 && !m_to));
      check("fail", 32'(bus.fail),
            32'(m_done && !(m_errs == 0 && !m_to)));
      check("timeout", 32'(bus.timeout), 32'(m_to));
      check("err_count", 32'(bus.err_count), m_errs);
      check("first_err_idx", 32'(bus.first_err_idx), m_first);
      check("cycle_count", bus.cycle_count, m_cyc);
`ifdef RESULT_CHECKER_CAPTURE_EN
      check("mism_got", bus.mism_got, m_got);
      check("mism_exp", bus.mism_exp, m_exp);
`endif
    end
  end

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    bus.start  = 1'b0;
    bus.exp_we = 1'b0;
    bus.valid  = 1'b0;
  endtask

  task automatic send(input logic [31:0] v);
    bus.valid  = 1'b1;
    bus.result = v;
    tick();
  endtask

  task automatic go(input int n);
    bus.exp_len = 5'(n);
    bus.start   = 1'b1;
    tick();
  endtask

  task automatic wait_done(input string nm);
    int n = 0;
    while (!bus.done && n < 600) begin
      tick();
      n++;
    end
    if (!bus.done) check(nm, 32'(bus.done), 32'd1);
  endtask

  logic [31:0] vals [4];
  logic [31:0] bads [4];

  initial begin
    vals[0] = 5;  vals[1] = 10; vals[2] = 15; vals[3] = 3;
    bads[0] = 5;  bads[1] = 11; bads[2] = 15; bads[3] = 4;
    rst = 1'b0;
    bus.exp_we = 0; bus.exp_addr = '0; bus.exp_data = '0;
    bus.exp_len = '0; bus.start = 0; bus.valid = 0;
    bus.result = '0;
    model_reset();
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_done", 32'(bus.done), 0);
    check("rst_cyc", bus.cycle_count, 0);
    chk_en = 1;
    rst = 1'b1;

    // Load table {5,10,15,3}.
    for (int i = 0; i < 4; i++) begin
      bus.exp_we = 1'b1;
      bus.exp_addr = 4'(i);
      bus.exp_data = vals[i];
      tick();
    end

    // Matching run; table write attempt mid-run must be ignored.
    go(4);
    check("t1_busy", 32'(bus.busy), 1);
    send(vals[0]);
    bus.exp_we = 1'b1; bus.exp_addr = '0; bus.exp_data = 99;
    send(vals[1]);
    send(vals[2]);
    check("t1_not_done", 32'(bus.done), 0);
    send(vals[3]);
    check("t1_done", 32'(bus.done), 1);
    check("t1_pass", 32'(bus.pass), 1);
    check("t1_err", 32'(bus.err_count), 0);
    tick();

    // Two mismatches.
    go(4);
    for (int i = 0; i < 4; i++) send(bads[i]);
    check("t2_fail", 32'(bus.fail), 1);
    check("t2_err", 32'(bus.err_count), 2);
    check("t2_first", 32'(bus.first_err_idx), 1);
`ifdef RESULT_CHECKER_CAPTURE_EN
    check("t2_got", bus.mism_got, 11);
    check("t2_exp", bus.mism_exp, 10);
`endif

    // Timeout with only two samples.
    go(4);
    send(vals[0]);
    send(vals[1]);
    wait_done("t3_wait");
    check("t3_cyc", bus.cycle_count, 400);
    check("t3_to", 32'(bus.timeout), 1);
    check("t3_fail", 32'(bus.fail), 1);

    // Final sample exactly on the last allowed cycle.
    go(4);
    for (int n = 0, k = 0; n < TO; n++) begin
      if (n < 3 || n == TO - 1) begin
        send(vals[k]);
        k++;
      end else begin
        tick();
      end
    end
    check("t4_done", 32'(bus.done), 1);
    check("t4_pass", 32'(bus.pass), 1);
    check("t4_to", 32'(bus.timeout), 0);
    check("t4_cyc", bus.cycle_count, 400);

    // Empty run.
    go(0);
    check("t5_busy", 32'(bus.busy), 1);
    check("t5_done0", 32'(bus.done), 0);
    tick();
    check("t5_done", 32'(bus.done), 1);
    check("t5_pass", 32'(bus.pass), 1);
    check("t5_busy0", 32'(bus.busy), 0);

    // Abort mid-run by reset, then rerun with retained table.
    go(4);
    send(vals[0]);
    send(vals[1]);
    #2;
    rst = 1'b0;
    model_reset();
    #1;
    check("t6_busy", 32'(bus.busy), 0);
    check("t6_cyc", bus.cycle_count, 0);
    @(negedge clk);
    rst = 1'b1;
    go(4);
    for (int i = 0; i < 4; i++) send(vals[i]);
    check("t6_pass", 32'(bus.pass), 1);
    check("t6_err", 32'(bus.err_count), 0);
    check("t6_cyc4", bus.cycle_count, 4);
    tick();
    @(negedge clk);
    chk_en = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
